// File: rtl/stage_defs_pkg.sv
// Shared stage codes and sequencer state encodings for the stage sequencer and the enable decoder.
package stage_defs_pkg;

  typedef enum logic [2:0] {
    STAGE_IDLE      = 3'd0,
    STAGE_FETCH     = 3'd1,
    STAGE_DECODE    = 3'd2,
    STAGE_EXECUTE   = 3'd3,
    STAGE_MEMORY    = 3'd4,
    STAGE_WRITEBACK = 3'd5
  } stage_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_PAUSED = 2'd3
  } seq_state_t;

  localparam int WAIT_W = 8;

  // Only fetch and memory stages may be held waiting on memory.
  function automatic logic is_mem_stage(input stage_t s);
    return (s == STAGE_FETCH) || (s == STAGE_MEMORY);
  endfunction

  function automatic stage_t succ_stage(input stage_t s);
    stage_t r;
    case (s)
      STAGE_FETCH:   r = STAGE_DECODE;
      STAGE_DECODE:  r = STAGE_EXECUTE;
      STAGE_EXECUTE: r = STAGE_MEMORY;
      STAGE_MEMORY:  r = STAGE_WRITEBACK;
      default:       r = STAGE_FETCH;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stage_sequencer_stall_timer.sv
// Memory wait counter: counts consecutive held cycles and flags a timeout at MAX_WAIT.
module stall_timer
  import stage_defs_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic hold,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_reg;
  logic [WAIT_W-1:0] wait_next;

  assign timeout = hold && (wait_reg == MAX_WAIT_C);

  // Any cycle that is not a genuine stall is an advance (or idle), so the count restarts.
  always_comb begin
    wait_next = '0;
    if (hold && !timeout) begin
      wait_next = wait_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wait_reg <= '0;
    end else begin
      wait_reg <= wait_next;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: emits Stage 1..5 per instruction, stalls on memory, counts retires.
// Optional single-step support is enabled by defining STAGE_SEQ_STEP_EN.
module stage_sequencer
  import stage_defs_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Halt_Request,
  input  logic             Mem_Access,
  input  logic             Mem_Ready,
`ifdef STAGE_SEQ_STEP_EN
  input  logic             Step_Mode,
  input  logic             Step,
`endif
  output logic [2:0]       Stage,
  output logic             Running,
  output logic             Stalled,
  output logic             Halted,
  output logic             Mem_Error,
  output logic [CNT_W-1:0] Instr_Count
);

  seq_state_t       state_reg, state_next;
  stage_t           stage_reg, stage_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hold;
  logic             timeout;
  logic             stall;

  assign hold  = (state_reg == ST_RUN) && is_mem_stage(stage_reg) && Mem_Access && !Mem_Ready;
  assign stall = hold && !timeout;

  stall_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_stall_timer (
    .clk    (Clock),
    .srst   (Reset),
    .hold   (hold),
    .timeout(timeout)
  );

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    err_next   = err_reg | timeout;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (Run) begin
          state_next = ST_RUN;
          stage_next = STAGE_FETCH;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (stage_reg == STAGE_WRITEBACK) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (Halt_Request) begin
              state_next = ST_HALTED;
              stage_next = STAGE_IDLE;
`ifdef STAGE_SEQ_STEP_EN
            end else if (Step_Mode) begin
              state_next = ST_PAUSED;
              stage_next = STAGE_IDLE;
`endif
            end else begin
              stage_next = STAGE_FETCH;
            end
          end else begin
            stage_next = succ_stage(stage_reg);
          end
        end
      end
`ifdef STAGE_SEQ_STEP_EN
      ST_PAUSED: begin
        if (Step || !Step_Mode) begin
          state_next = ST_RUN;
          stage_next = STAGE_FETCH;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
        stage_next = STAGE_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      stage_reg <= STAGE_IDLE;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign Stage       = stage_reg;
  assign Running     = (state_reg == ST_RUN);
  assign Halted      = (state_reg == ST_HALTED);
  assign Stalled     = stall;
  assign Mem_Error   = err_reg;
  assign Instr_Count = cnt_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: per-cycle behavioural model plus directed literal checks.
module tb_stage_sequencer;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 8;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             Run = 1'b0;
  logic             Halt_Request = 1'b0;
  logic             Mem_Access = 1'b0;
  logic             Mem_Ready = 1'b0;
  logic [2:0]       Stage;
  logic             Running;
  logic             Stalled;
  logic             Halted;
  logic             Mem_Error;
  logic [CNT_W-1:0] Instr_Count;

  stage_sequencer #(
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Run         (Run),
    .Halt_Request(Halt_Request),
    .Mem_Access  (Mem_Access),
    .Mem_Ready   (Mem_Ready),
    .Stage       (Stage),
    .Running     (Running),
    .Stalled     (Stalled),
    .Halted      (Halted),
    .Mem_Error   (Mem_Error),
    .Instr_Count (Instr_Count)
  );

  always #5 Clock = ~Clock;

  int tests  = 0;
  int errors = 0;

  // Model: mode 0=idle, 1=running, 2=halted.
  int m_mode, m_stage, m_wait, m_err, m_cnt;

  // Values seen on the most recent cycle, for directed literal checks.
  int obs_stage, obs_stalled, obs_err, obs_cnt, obs_halted, obs_running;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_stage = 0; m_wait = 0; m_err = 0; m_cnt = 0;
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model over the edge.
  task automatic cycle(input bit rst, input bit run, input bit halt, input bit ma, input bit mr);
    bit hold, tmo, stl;
    @(negedge Clock);
    Reset = rst; Run = run; Halt_Request = halt; Mem_Access = ma; Mem_Ready = mr;
    #1;
    hold = (m_mode == 1) && (m_stage == 1 || m_stage == 4) && ma && !mr;
    tmo  = hold && (m_wait == MAX_WAIT);
    stl  = hold && !tmo;
    chk("stage",   32'(Stage),       32'(m_stage));
    chk("running", 32'(Running),     32'(m_mode == 1));
    chk("halted",  32'(Halted),      32'(m_mode == 2));
    chk("stalled", 32'(Stalled),     32'(stl));
    chk("mem_err", 32'(Mem_Error),   32'(m_err));
    chk("count",   32'(Instr_Count), 32'(m_cnt));
    obs_stage = int'(Stage); obs_stalled = int'(Stalled); obs_err = int'(Mem_Error);
    obs_cnt = int'(Instr_Count); obs_halted = int'(Halted); obs_running = int'(Running);
    if (rst) begin
      model_reset();
    end else if (m_mode == 1) begin
      if (tmo) m_err = 1;
      if (stl) begin
        m_wait++;
      end else begin
        m_wait = 0;
        if (m_stage == 5) begin
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          if (halt) begin m_mode = 2; m_stage = 0; end
          else m_stage = 1;
        end else begin
          m_stage++;
        end
      end
    end else if (run) begin
      m_mode = 1; m_stage = 1; m_wait = 0;
    end
  endtask

  initial begin
    int seen[10];
    int n_stage, n_stall, saw15;
    model_reset();
    repeat (2) @(posedge Clock);

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("rst_stage", 32'(obs_stage), 32'd0);
    chk("rst_count", 32'(obs_cnt), 32'd0);

    // Free-running sequence after a one-cycle Run pulse
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0);
      seen[i] = obs_stage;
    end
    for (int i = 0; i < 10; i++) chk("seq_stage", 32'(seen[i]), 32'((i % 5) + 1));

    // Fetch stall: three held cycles then ready
    n_stage = 0; n_stall = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, i == 3);
      if (i == 0) chk("count_after_10", 32'(obs_cnt), 32'd2);
      if (obs_stage == 1) n_stage++;
      n_stall += obs_stalled;
    end
    chk("fetch_hold_cycles", 32'(n_stage), 32'd4);
    chk("fetch_stall_cycles", 32'(n_stall), 32'd3);
    cycle(0, 0, 0, 0, 0);
    chk("after_fetch_stall", 32'(obs_stage), 32'd2);
    chk("no_err_after_stall", 32'(obs_err), 32'd0);

    // Memory stage timeout
    cycle(0, 0, 0, 0, 0);
    n_stage = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 1, 0);
      if (obs_stage == 4) n_stage++;
    end
    chk("timeout_hold_cycles", 32'(n_stage), 32'd9);

    // Halt out of writeback
    cycle(0, 0, 1, 0, 0);
    chk("after_timeout_stage", 32'(obs_stage), 32'd5);
    chk("err_set", 32'(obs_err), 32'd1);
    cycle(0, 0, 0, 0, 0);
    chk("halt_stage", 32'(obs_stage), 32'd0);
    chk("halt_flag", 32'(obs_halted), 32'd1);
    chk("halt_count", 32'(obs_cnt), 32'd3);
    chk("err_sticky", 32'(obs_err), 32'd1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("resume_stage", 32'(obs_stage), 32'd1);
    chk("resume_halted", 32'(obs_halted), 32'd0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("halt_ignored", 32'(obs_stage), 32'd4);

    // Reset during a memory stall
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    chk("prereset_stall", 32'(obs_stalled), 32'd1);
    cycle(0, 0, 0, 1, 0);
    chk("midreset_stage", 32'(obs_stage), 32'd0);
    chk("midreset_count", 32'(obs_cnt), 32'd0);
    chk("midreset_err", 32'(obs_err), 32'd0);

    // Counter wrap: 16 instructions on a 4-bit counter
    cycle(0, 1, 0, 0, 0);
    saw15 = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (obs_cnt == 15) saw15 = 1;
    end
    cycle(0, 0, 0, 0, 0);
    chk("wrap_saw15", 32'(saw15), 32'd1);
    chk("wrap_count", 32'(obs_cnt), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
